// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O helpers (LED stretcher, input debouncer).
// Holds the blink FSM state encoding and the ms-to-cycles parameter math.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    // Converts a duration in milliseconds to clock cycles for a clock given in MHz.
    function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned mhz);
        return ms * mhz * 1000;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the expired state.
module ms_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle status strobes into visible LED blinks with minimum ON/OFF times.
// Events arriving during a blink are queued in a saturating counter and replayed as blinks.
module led_pulse_stretcher
    import board_io_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50,
    parameter int unsigned ON_TIME         = 50,
    parameter int unsigned OFF_TIME        = 50,
    parameter int unsigned MAX_PENDING     = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               event_in,
    input  logic                               clear_overflow,
    output logic                               led_out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic                               overflow
);

    localparam int unsigned N_ON  = ms_to_cycles(ON_TIME, CLOCK_FREQUENCY);
    localparam int unsigned N_OFF = ms_to_cycles(OFF_TIME, CLOCK_FREQUENCY);
    localparam int unsigned N_MAX = (N_ON > N_OFF) ? N_ON : N_OFF;
    localparam int unsigned TW    = $clog2(N_MAX + 1);
    localparam int unsigned PW    = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] ON_LOAD  = TW'(N_ON - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(N_OFF - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    state_e          state_q, state_d;
    logic            led_q, led_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic            ovf_q, ovf_d;

    logic            tmr_load;
    logic [TW-1:0]   tmr_value;
    logic            tmr_zero;
    logic            dec;
    logic            inc;
    logic            ovf_set;

    ms_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .zero_o       (tmr_zero)
    );

    // Phase sequencing; a queued event in IDLE starts a blink just like a fresh strobe.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        dec       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && (event_in || pend_q != '0)) begin
                    state_d   = ON;
                    tmr_load  = 1'b1;
                    tmr_value = ON_LOAD;
                    dec       = (pend_q != '0);
                end
            end
            ON: begin
                if (tmr_zero) begin
                    state_d   = OFF;
                    tmr_load  = 1'b1;
                    tmr_value = OFF_LOAD;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    if (enable && pend_q != '0) begin
                        state_d   = ON;
                        tmr_load  = 1'b1;
                        tmr_value = ON_LOAD;
                        dec       = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe in IDLE with an empty queue is consumed by the blink it starts.
    always_comb begin
        inc     = enable && event_in && !(state_q == IDLE && pend_q == '0);
        ovf_set = 1'b0;
        pend_d  = pend_q;
        if (!enable) begin
            pend_d = '0;
        end else if (inc && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PW'(1);
        end
        ovf_d = ovf_set ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
        led_d = (state_d == ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led_out       = led_q;
    assign busy          = (state_q != IDLE);
    assign pending_count = pend_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed and randomized bench for led_pulse_stretcher (1 MHz clock, 1 ms ON, 2 ms OFF, queue depth 3).
// The reference model tracks each blink as a start cycle plus elapsed position on a timeline.
module tb_led_pulse_stretcher;

    localparam int N_ON  = 1000;
    localparam int N_OFF = 2000;
    localparam int MAXP  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       event_in;
    logic       clear_overflow;
    logic       led_out;
    logic       busy;
    logic [1:0] pending_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int rises  = 0;
    int r0;
    logic led_prev = 1'b0;

    // Reference model: blink timeline position and queue contents
    bit m_active = 1'b0;
    int m_pos    = 0;
    int m_pend   = 0;
    bit m_ovf    = 1'b0;
    bit m_led    = 1'b0;

    led_pulse_stretcher #(
        .CLOCK_FREQUENCY (1),
        .ON_TIME         (1),
        .OFF_TIME        (2),
        .MAX_PENDING     (MAXP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .event_in       (event_in),
        .clear_overflow (clear_overflow),
        .led_out        (led_out),
        .busy           (busy),
        .pending_count  (pending_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s differs", tag);
        end
    endtask

    task automatic model_edge(input logic ev, input logic en, input logic clr, input logic rst);
        bit set_ovf;
        bit ev_ok;
        set_ovf = 1'b0;
        ev_ok   = ev && en;
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_pend   = 0;
            m_ovf    = 1'b0;
        end else begin
            if (!m_active) begin
                if (en && (ev || m_pend > 0)) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    if (m_pend > 0 && !ev) m_pend--;
                end
            end else if (m_pos == N_ON + N_OFF - 1) begin
                if (en && m_pend > 0) begin
                    m_pos = 0;
                    if (!ev_ok) m_pend--;
                end else begin
                    m_active = 1'b0;
                    if (ev_ok) begin
                        if (m_pend == MAXP) set_ovf = 1'b1;
                        else m_pend++;
                    end
                end
            end else begin
                m_pos++;
                if (ev_ok) begin
                    if (m_pend == MAXP) set_ovf = 1'b1;
                    else m_pend++;
                end
            end
            if (!en) m_pend = 0;
            if (set_ovf) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        m_led = m_active && (m_pos < N_ON);
    endtask

    task automatic tick(input logic ev, input logic en, input logic clr, input logic rst);
        logic [4:0] exp_v;
        event_in       = ev;
        enable         = en;
        clear_overflow = clr;
        reset          = rst;
        @(posedge clk);
        model_edge(ev, en, clr, rst);
        #1;
        if (led_out === 1'b1 && led_prev !== 1'b1) rises++;
        led_prev = led_out;
        exp_v = {m_led, m_active, 2'(m_pend), m_ovf};
        check("cycle", 32'({led_out, busy, pending_count, overflow}), 32'(exp_v));
    endtask

    task automatic run(input int n, input logic en);
        repeat (n) tick(1'b0, en, 1'b0, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        event_in       = 1'b0;
        clear_overflow = 1'b0;

        tick(0, 0, 0, 1);
        tick(0, 1, 0, 1);
        check("rst_state", 32'({led_out, busy, pending_count, overflow}), 32'd0);

        // Single event: one-cycle latency, exact ON and OFF lengths
        run(10, 1);
        r0 = rises;
        tick(1, 1, 0, 0);
        check("t1_latency", 32'(led_out), 32'd1);
        check("t1_no_pend", 32'(pending_count), 32'd0);
        run(999, 1);
        check("t1_on_last", 32'(led_out), 32'd1);
        run(1, 1);
        check("t1_off_first", 32'(led_out), 32'd0);
        run(1999, 1);
        check("t1_off_last_busy", 32'(busy), 32'd1);
        run(1, 1);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_blinks", 32'(rises - r0), 32'd1);

        // Three spaced events become three blinks
        r0 = rises;
        tick(1, 1, 0, 0);
        run(9, 1);
        tick(1, 1, 0, 0);
        run(9, 1);
        tick(1, 1, 0, 0);
        check("t2_pend2", 32'(pending_count), 32'd2);
        run(2980, 1);
        check("t2_b2_led", 32'(led_out), 32'd1);
        check("t2_b2_pend", 32'(pending_count), 32'd1);
        run(3000, 1);
        check("t2_b3_led", 32'(led_out), 32'd1);
        check("t2_b3_pend", 32'(pending_count), 32'd0);
        run(3000, 1);
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_blinks", 32'(rises - r0), 32'd3);

        // Saturation and sticky overflow
        r0 = rises;
        tick(1, 1, 0, 0);
        repeat (6) tick(1, 1, 0, 0);
        check("t3_pend_sat", 32'(pending_count), 32'd3);
        check("t3_ovf_set", 32'(overflow), 32'd1);
        run(12000, 1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_blinks", 32'(rises - r0), 32'd4);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        tick(0, 1, 1, 0);
        check("t3_ovf_clear", 32'(overflow), 32'd0);
        tick(1, 1, 0, 0);
        repeat (3) tick(1, 1, 0, 0);
        check("t3_pend_full", 32'(pending_count), 32'd3);
        tick(1, 1, 1, 0);
        check("t3_set_wins", 32'(overflow), 32'd1);
        tick(0, 1, 1, 0);
        check("t3_clear_again", 32'(overflow), 32'd0);
        tick(0, 0, 0, 0);
        run(3000, 1);
        check("t3_drain_idle", 32'(busy), 32'd0);

        // Event on the OFF-expiry edge while one blink is queued
        r0 = rises;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        run(2998, 1);
        check("t4_off_end", 32'({led_out, busy, pending_count}), 32'b0_1_01);
        tick(1, 1, 0, 0);
        check("t4_next_blink", 32'({led_out, busy, pending_count}), 32'b1_1_01);
        run(6000, 1);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_blinks", 32'(rises - r0), 32'd3);

        // enable=0 mid-ON flushes the queue but lets the current blink finish
        r0 = rises;
        repeat (3) tick(1, 1, 0, 0);
        check("t5_pend2", 32'(pending_count), 32'd2);
        tick(1, 0, 0, 0);
        check("t5_flush", 32'({led_out, pending_count}), 32'b1_00);
        for (int i = 0; i < 2996; i++) tick(logic'(i % 7 == 0), 0, 0, 0);
        check("t5_off_end", 32'({led_out, busy}), 32'b01);
        tick(1, 0, 0, 0);
        check("t5_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 50; i++) tick(logic'(i % 3 == 0), 0, 0, 0);
        check("t5_no_blinks", 32'(rises - r0), 32'd1);
        check("t5_still_idle", 32'({busy, pending_count}), 32'd0);

        // Reset mid-ON aborts the blink, then normal latency afterwards
        tick(1, 1, 0, 0);
        repeat (4) tick(1, 1, 0, 0);
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        run(100, 1);
        tick(0, 1, 0, 1);
        check("t6_reset", 32'({led_out, busy, pending_count, overflow}), 32'd0);
        tick(0, 1, 0, 0);
        check("t6_quiet", 32'(led_out), 32'd0);
        tick(1, 1, 0, 0);
        check("t6_relaunch", 32'({led_out, busy, pending_count}), 32'b1_1_00);
        tick(0, 1, 0, 1);

        // Randomized traffic at three event densities
        for (int seg = 0; seg < 3; seg++) begin
            int dens;
            dens = (seg == 0) ? 40 : ((seg == 1) ? 500 : 1500);
            for (int i = 0; i < 5000; i++) begin
                logic ev, en, clr, rst;
                ev  = ($urandom_range(dens - 1, 0) == 0);
                en  = ($urandom_range(99, 0) < 95);
                clr = ($urandom_range(199, 0) == 0);
                rst = ($urandom_range(2999, 0) == 0);
                tick(ev, en, clr, rst);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
Output-side counterpart of the input debouncer: turns single-cycle internal events into human-visible LED blinks. Each blink has a guaranteed minimum ON time and minimum OFF gap. Events arriving during a blink are queued in a saturating counter, so bursts become a countable blink sequence rather than one merged pulse. Sits between status logic (errors, packet received, trigger fired) and the board LED pins.

Parameters:
CLOCK_FREQUENCY, 50, clk frequency in MHz
ON_TIME, 50, LED ON duration in ms; N_ON = ON_TIME*CLOCK_FREQUENCY*1000 cycles
OFF_TIME, 50, mandatory dark gap after each blink in ms; N_OFF = OFF_TIME*CLOCK_FREQUENCY*1000 cycles
MAX_PENDING, 15, saturation value of the pending-event queue (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = accept events; 0 = drop new events and flush the queue
event_in  input  1  synchronous event strobe; every high cycle counts as one event
clear_overflow  input  1  clears the sticky overflow flag
led_out  output  1  registered LED drive, active-high
busy  output  1  high whenever state != IDLE
pending_count  output  $clog2(MAX_PENDING+1)  number of queued blinks not yet started
overflow  output  1  sticky flag: an event was lost to saturation

Behaviour:
- Reset (clk, reset synchronous active-high): state IDLE, led_out=0, busy=0, pending_count=0, overflow=0, timer=0. Reset mid-blink aborts the blink immediately, with no OFF gap.
- Timer: a single down-counter sized to $clog2(max(N_ON,N_OFF)+1) bits.
- State IDLE:
  - On event_in=1 with enable=1 at edge k, go to ON, set led_out=1 after edge k, and load the timer with N_ON-1.
  - The triggering event is not added to pending.
  - Latency is one cycle from the strobe to the LED.
- State ON:
  - led_out=1 for exactly N_ON cycles.
  - At timer==0, go to OFF, set led_out=0, and load the timer with N_OFF-1.
- State OFF:
  - led_out=0 for exactly N_OFF cycles.
  - At timer==0 with pending>0: decrement pending, go to ON, load N_ON-1.
  - At timer==0 with pending==0: go to IDLE.
- Queueing: event_in=1 with enable=1 while in ON or OFF increments pending.
- Simultaneous events:
  - An event in the same cycle as the OFF-expiry decrement leaves pending unchanged, and the next blink starts.
  - An event in the same cycle as the ON-to-OFF or OFF-to-IDLE transition is counted normally.
  - An event on the OFF-to-IDLE edge with pending==0 yields pending=1 and state IDLE; on the next cycle IDLE sees pending>0.
- Pending in IDLE: IDLE treats pending>0 as an event. It decrements pending and goes to ON, so no event is ever stranded.
- Saturation: an increment when pending==MAX_PENDING leaves pending at MAX_PENDING and sets overflow=1. overflow stays high until clear_overflow=1 or reset.
- Overflow set vs clear: if set and clear occur in the same cycle, set wins.
- enable=0:
  - event_in is ignored and pending is cleared to 0 on the next edge.
  - A blink in progress completes its ON and OFF phases, then returns to IDLE.
  - overflow is not affected.
- Glitch-free output: led_out comes directly from a flop and never toggles more than once per phase.

Decomposition:
- Shared package (board_io_pkg):
  - state encoding constants: IDLE=2'd0, ON=2'd1, OFF=2'd2
  - ms-to-cycles constant function, also reused by the debouncer parameter math
- One natural sub-module, ms_timer: a loadable down-counter with load, load_value and zero-flag outputs. The FSM, queue counter and overflow logic stay in the top module.

Test Plan:
1. Params CLOCK_FREQUENCY=1, ON_TIME=1, OFF_TIME=2 (N_ON=1000, N_OFF=2000). Single event_in pulse at cycle 10 -> led_out=1 on cycles 11..1010, 0 from 1011; busy drops after cycle 3010; pending stays 0.
2. Same params, 3 pulses at cycles 10, 20, 30 -> pending rises to 2. Exactly 3 blinks, each 1000 cycles ON with a 2000-cycle gap; pending reads 1 after the 2nd blink starts and 0 after the 3rd.
3. MAX_PENDING=3, 6 back-to-back events during the first blink -> pending saturates at 3 and overflow=1. Exactly 4 blinks total. clear_overflow pulse -> overflow=0; simultaneous set and clear -> overflow=1.
4. Event coinciding with the OFF-expiry cycle while pending=1 -> pending stays 1 and the next blink starts without an IDLE cycle.
5. enable=0 mid-ON with pending=2 -> pending=0 next cycle, the current blink finishes ON and OFF, then IDLE. Events during enable=0 produce no blinks.
6. reset asserted mid-ON -> next cycle led_out=0, busy=0, pending_count=0, overflow=0. A new event after reset deasserts blinks normally with 1-cycle latency.
